// File: rtl/preg_free_list.sv
// Free list of physical register tags between ROB commit and Rename: a show-ahead
// circular FIFO of free tags plus a membership bitmap that catches double, late and overflowing frees.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH  = 32,
    parameter int DEPTH     = NUM_PREGS - NUM_ARCH,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              alloc_valid_o,
    output logic [PREG_W-1:0] alloc_preg_o,
    input  logic              alloc_i,
    input  logic              free_valid_i,
    input  logic [PREG_W-1:0] free_preg_i,
    output logic [PREG_W:0]   count_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PREG_W:0]   CNT_FULL = (PREG_W+1)'(DEPTH);
    localparam logic [PREG_W:0]   CNT_ONE  = (PREG_W+1)'(1);
    localparam logic [PREG_W:0]   CNT_ZERO = (PREG_W+1)'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(0);
    localparam logic [PREG_W-1:0] TAG_ZERO = PREG_W'(0);

    logic [PREG_W-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [PREG_W:0]      cnt_r;
    logic [NUM_PREGS-1:0] free_map_r;
    logic                 err_r;

    logic                 alloc_valid_s;
    logic [PREG_W-1:0]    head_tag_s;
    logic                 pop_s;
    logic                 tag_live_s;
    logic                 in_map_s;
    logic                 full_s;
    logic                 free_ok_s;
    logic                 free_err_s;
    logic [PREG_W:0]      cnt_nxt_s;
    logic [NUM_PREGS-1:0] map_nxt_s;

    // Pop/push decisions and next count/bitmap; a pop at full makes room for a same-cycle free.
    always_comb begin
        alloc_valid_s = (cnt_r != CNT_ZERO);
        head_tag_s    = mem_r[head_r];
        pop_s         = alloc_i && alloc_valid_s;
        tag_live_s    = (free_preg_i != TAG_ZERO);
        in_map_s      = free_map_r[free_preg_i];
        full_s        = (cnt_r == CNT_FULL);
        free_ok_s     = free_valid_i && tag_live_s && !in_map_s && (!full_s || pop_s);
        free_err_s    = free_valid_i && tag_live_s && (in_map_s || (full_s && !pop_s));

        case ({pop_s, free_ok_s})
            2'b10:   cnt_nxt_s = cnt_r - CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r + CNT_ONE;
            default: cnt_nxt_s = cnt_r;
        endcase

        // Popped and freed tags never coincide when free_ok_s is set (the popped tag is still mapped).
        map_nxt_s              = free_map_r;
        map_nxt_s[head_tag_s]  = free_map_r[head_tag_s] & ~pop_s;
        map_nxt_s[free_preg_i] = map_nxt_s[free_preg_i] | free_ok_s;
    end

    // State registers; reset loads tags NUM_ARCH..NUM_PREGS-1 as the initial free pool.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= PREG_W'(NUM_ARCH + i);
            end
            for (int p = 0; p < NUM_PREGS; p++) begin
                free_map_r[p] <= (p >= NUM_ARCH);
            end
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
            cnt_r  <= CNT_FULL;
            err_r  <= 1'b0;
        end else begin
            if (free_ok_s) begin
                mem_r[tail_r] <= free_preg_i;
                tail_r        <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            cnt_r      <= cnt_nxt_s;
            free_map_r <= map_nxt_s;
            err_r      <= err_r | free_err_s;
        end
    end

    assign alloc_valid_o = alloc_valid_s;
    assign alloc_preg_o  = head_tag_s;
    assign count_o       = cnt_r;
    assign err_o         = err_r;

    preg_free_list_chk #(
        .NUM_PREGS (NUM_PREGS),
        .DEPTH     (DEPTH),
        .PREG_W    (PREG_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt_r),
        .free_map (free_map_r)
    );

endmodule

// Structural invariants of the free list: bounded count, bitmap agrees with count, x0 never free.
module preg_free_list_chk #(
    parameter int NUM_PREGS = 64,
    parameter int DEPTH     = 32,
    parameter int PREG_W    = 6
) (
    input logic                 clk,
    input logic                 rst,
    input logic [PREG_W:0]      cnt,
    input logic [NUM_PREGS-1:0] free_map
);

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt <= (PREG_W+1)'(DEPTH));

    a_map_count: assert property (@(posedge clk) disable iff (rst)
        $countones(free_map) == int'(cnt));

    a_x0_never_free: assert property (@(posedge clk) disable iff (rst)
        free_map[0] == 1'b0);

endmodule

// File: tb/tb_preg_free_list.sv
// Randomized and directed bench for preg_free_list; a queue-based reference model feeds a
// scoreboard that a negedge monitor drains and compares against the DUT outputs.
module tb_preg_free_list;

    logic       clk;
    logic       rst = 1'b1;
    logic       alloc_valid_o;
    logic [5:0] alloc_preg_o;
    logic       alloc_i = 1'b0;
    logic       free_valid_i = 1'b0;
    logic [5:0] free_preg_i = 6'd0;
    logic [6:0] count_o;
    logic       err_o;

    preg_free_list dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid_o (alloc_valid_o),
        .alloc_preg_o  (alloc_preg_o),
        .alloc_i       (alloc_i),
        .free_valid_i  (free_valid_i),
        .free_preg_i   (free_preg_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    typedef struct {
        bit       valid;
        bit [5:0] tag;
        bit [6:0] cnt;
        bit       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: ordered queue of free tags, membership set, sticky error.
    int   model_q[$];
    bit   model_in[64];
    bit   model_err;

    bit   rand_phase = 1'b0;
    bit   held[64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        model_q.delete();
        for (int p = 0; p < 64; p++) model_in[p] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model_q.push_back(32 + i);
            model_in[32 + i] = 1'b1;
        end
        model_err = 1'b0;
    endfunction

    function automatic void model_step(input bit a, input bit fv, input int ft);
        bit pop;
        bit accept;
        pop    = a && (model_q.size() > 0);
        accept = 1'b0;
        if (fv && ft != 0) begin
            if (model_in[ft])                     model_err = 1'b1;
            else if (model_q.size() == 32 && !pop) model_err = 1'b1;
            else                                  accept = 1'b1;
        end
        if (pop) begin
            model_in[model_q[0]] = 1'b0;
            void'(model_q.pop_front());
        end
        if (accept) begin
            model_q.push_back(ft);
            model_in[ft] = 1'b1;
        end
    endfunction

    // Drive one cycle of inputs just after a rising edge and queue the outputs expected for it.
    task automatic step(input bit r, input bit a, input bit fv, input int ft);
        exp_t e;
        rst          = r;
        alloc_i      = a;
        free_valid_i = fv;
        free_preg_i  = 6'(ft);
        if (r) model_reset();
        e.valid = (model_q.size() != 0);
        e.tag   = e.valid ? 6'(model_q[0]) : 6'd0;
        e.cnt   = 7'(model_q.size());
        e.err   = model_err;
        exp_q.push_back(e);
        if (!r) model_step(a, fv, ft);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("alloc_valid", int'(alloc_valid_o), int'(mon_e.valid));
            if (mon_e.valid) chk("alloc_preg", int'(alloc_preg_o), int'(mon_e.tag));
            chk("count", int'(count_o), int'(mon_e.cnt));
            chk("err", int'(err_o), int'(mon_e.err));
            if (rand_phase) begin
                if (alloc_i && alloc_valid_o) begin
                    chk("realloc_unique", int'(held[alloc_preg_o]), 0);
                    held[alloc_preg_o] = 1'b1;
                end
                if (free_valid_i && free_preg_i != 6'd0) held[free_preg_i] = 1'b0;
            end
        end
    end

    initial begin
        int held_q[$];
        int idx;
        int ft;
        bit a;
        bit fv;

        @(posedge clk);
        #1;

        // Reset image, drain 32..63, then allocate while empty.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 1'b0, 0);

        // Refill from empty with alloc held: no bypass of the freed tag.
        step(1'b0, 1'b1, 1'b1, 40);
        step(1'b0, 1'b1, 1'b1, 7);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);

        // Simultaneous pop and free at full; tag 5 reaches head after 31 more pops.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 5);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 0);

        // Double free of a tag already in the list.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 40);
        step(1'b0, 1'b0, 1'b0, 0);

        // Overflow: freeing an architectural tag while full without a pop.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 1'b0, 0);

        // Free of tag 0 is silently dropped.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 0);

        // Free 32 twice after allocating it; second one is a double free.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 32);
        step(1'b0, 1'b0, 1'b1, 32);
        step(1'b0, 1'b0, 1'b0, 0);

        // Mid-operation reset with traffic on the inputs.
        step(1'b0, 1'b1, 1'b1, 33);
        step(1'b1, 1'b1, 1'b1, 9);
        step(1'b0, 1'b0, 1'b0, 0);

        // Random run: a ROB-like producer frees only tags it holds beyond the 31 architectural mappings.
        do_reset();
        for (int t = 1; t < 32; t++) held_q.push_back(t);
        for (int p = 0; p < 64; p++) held[p] = (p > 0 && p < 32);
        rand_phase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            a  = ($urandom_range(0, 3) != 0);
            fv = 1'b0;
            ft = 0;
            if (held_q.size() > 31 && $urandom_range(0, 2) != 0) begin
                idx = $urandom_range(0, held_q.size() - 1);
                ft  = held_q[idx];
                held_q.delete(idx);
                fv  = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                fv = 1'b1;
            end
            if (a && model_q.size() > 0) held_q.push_back(model_q[0]);
            step(1'b0, a, fv, ft);
        end
        rand_phase = 1'b0;

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
